// File: rtl/menu_pkg.sv
// Shared constants and FSM encoding for the menu/OSD text reader.
package menu_pkg;
  localparam int MENU_COLS = 32;
  localparam int GLYPH_H   = 8;

  localparam logic [10:0] DEF_FONT_BASE = 11'h400;
  localparam logic [10:0] DEF_TEXT_BASE = 11'h000;

  typedef enum logic [1:0] {IDLE, CHAR, GLYPH, DRAIN} state_e;
endpackage

// File: rtl/menu_line_buf.sv
// Double-buffered scanline store: 32 glyph bytes + invert bits + blank flag per bank.
module menu_line_buf
  import menu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       swap_i,
  input  logic       set_back_blank_i,
  input  logic       set_front_blank_i,
  input  logic       clr_back_blank_i,
  input  logic       we_glyph_i,
  input  logic       we_inv_i,
  input  logic [4:0] wr_col_i,
  input  logic [7:0] wr_data_i,
  input  logic [4:0] rd_col_i,
  input  logic [2:0] rd_bit_i,
  output logic       rd_pix_o
);

  logic [1:0][MENU_COLS-1:0][7:0] glyph_q;
  logic [1:0][MENU_COLS-1:0]      inv_q;
  logic [1:0]                     blank_q;
  logic                           front_q;
  logic                           back;

  assign back = ~front_q;

  always_ff @(posedge clk) begin
    if (we_glyph_i) glyph_q[back][wr_col_i] <= wr_data_i;
    if (we_inv_i)   inv_q[back][wr_col_i]   <= wr_data_i[7];
  end

  // Blank controls are expressed against the pre-swap bank roles.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= 2'b11;
      front_q <= 1'b0;
    end else begin
      if (swap_i)            front_q         <= ~front_q;
      if (set_back_blank_i)  blank_q[back]    <= 1'b1;
      if (set_front_blank_i) blank_q[front_q] <= 1'b1;
      if (clr_back_blank_i)  blank_q[back]    <= 1'b0;
    end
  end

  assign rd_pix_o = ~blank_q[front_q] &
                    (glyph_q[front_q][rd_col_i][rd_bit_i] ^ inv_q[front_q][rd_col_i]);

endmodule

// File: rtl/menu_text_reader.sv
// Per-scanline text/glyph fetch from the OSD RAM into a line buffer, plus the pixel register.
module menu_text_reader
  import menu_pkg::*;
#(
  parameter logic [10:0] FONT_BASE = DEF_FONT_BASE,
  parameter logic [10:0] TEXT_BASE = DEF_TEXT_BASE,
  parameter int          TEXT_ROWS = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  output logic        busy,
  output logic        ram_ce,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_dout,
  input  logic        overlay_en,
  input  logic        pix_req,
  input  logic [7:0]  pix_x,
  output logic        pix_valid,
  output logic        pix
);

  localparam int LAST_Y = TEXT_ROWS * GLYPH_H;

  state_e     state_q;
  logic [4:0] col_q;
  logic [4:0] row_q;
  logic [2:0] r_q;
  logic       pix_valid_q;
  logic       pix_q;
  logic       in_text;
  logic       buf_pix;
  logic [4:0] wr_col;

  assign in_text = (int'(line_y) < LAST_Y);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      r_q     <= '0;
    end else if (line_start) begin
      col_q   <= '0;
      row_q   <= line_y[7:3];
      r_q     <= line_y[2:0];
      state_q <= in_text ? CHAR : IDLE;
    end else begin
      case (state_q)
        CHAR:    state_q <= GLYPH;
        GLYPH: begin
          if (col_q == 5'(MENU_COLS - 1)) state_q <= DRAIN;
          else begin
            state_q <= CHAR;
            col_q   <= col_q + 5'd1;
          end
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The glyph address depends on the code arriving this cycle, so the bus is decoded, not registered.
  always_comb begin
    ram_ce   = 1'b0;
    ram_addr = '0;
    case (state_q)
      CHAR: begin
        ram_ce   = 1'b1;
        ram_addr = TEXT_BASE + {1'b0, row_q, col_q};
      end
      GLYPH: begin
        ram_ce   = 1'b1;
        ram_addr = FONT_BASE + {1'b0, ram_dout[6:0], r_q};
      end
      default: ;
    endcase
  end

  // In CHAR the byte on ram_dout belongs to the previous column.
  assign wr_col = (state_q == CHAR) ? col_q - 5'd1 : col_q;

  menu_line_buf u_buf (
    .clk              (clk),
    .reset            (reset),
    .swap_i           (line_start),
    .set_back_blank_i (line_start & busy),
    .set_front_blank_i(line_start & ~in_text),
    .clr_back_blank_i ((state_q == DRAIN) & ~line_start),
    .we_glyph_i       ((((state_q == CHAR) && (col_q != 5'd0)) || (state_q == DRAIN)) & ~line_start),
    .we_inv_i         ((state_q == GLYPH) & ~line_start),
    .wr_col_i         (wr_col),
    .wr_data_i        (ram_dout),
    .rd_col_i         (pix_x[7:3]),
    .rd_bit_i         (pix_x[2:0]),
    .rd_pix_o         (buf_pix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_q       <= 1'b0;
    end else begin
      pix_valid_q <= pix_req;
      if (pix_req) pix_q <= overlay_en & buf_pix;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix       = pix_q;

endmodule

// File: tb/tb_menu_text_reader.sv
// Randomized bench for menu_text_reader against a line-image reference model.
module tb_menu_text_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  line_y = '0;
  logic        busy;
  logic        ram_ce;
  logic [10:0] ram_addr;
  logic [7:0]  ram_dout = '0;
  logic        overlay_en = 1'b0;
  logic        pix_req = 1'b0;
  logic [7:0]  pix_x = '0;
  logic        pix_valid;
  logic        pix;

  menu_text_reader dut (
    .clk       (clk),
    .reset     (reset),
    .line_start(line_start),
    .line_y    (line_y),
    .busy      (busy),
    .ram_ce    (ram_ce),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .overlay_en(overlay_en),
    .pix_req   (pix_req),
    .pix_x     (pix_x),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [2048];
  always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_addr];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Model: whole 256-pixel images for the front and back line
  bit [255:0] m_front, m_back;
  bit         m_front_ok = 1'b0;
  bit         m_back_ok  = 1'b0;
  int         m_back_ready = 0;
  bit         last_pix = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit ref_pix(input int y, input int x);
    logic [7:0] c, g;
    if (y >= 224) return 1'b0;
    c = mem[(y / 8) * 32 + x / 8];
    g = mem[(1024 + int'(c[6:0]) * 8 + y % 8) % 2048];
    return g[x % 8] ^ c[7];
  endfunction

  task automatic step(input bit ls, input logic [7:0] y, input bit req,
                      input logic [7:0] x, input bit en);
    int e;
    line_start = ls; line_y = y; pix_req = req; pix_x = x; overlay_en = en;
    if (req) last_pix = en & m_front_ok & m_front[x];
    if (ls) begin
      e = cyc + 1;
      m_front_ok = m_back_ok && (e >= m_back_ready);
      m_front    = m_back;
      for (int i = 0; i < 256; i++) m_back[i] = ref_pix(int'(y), i);
      m_back_ok    = 1'b1;
      m_back_ready = (y < 8'd224) ? e + 66 : e;
    end
    @(posedge clk); #1; cyc++;
    line_start = 1'b0; pix_req = 1'b0;
    chk("pix_valid", 32'(pix_valid), 32'(req));
    chk("pix", 32'(pix), 32'(last_pix));
  endtask

  task automatic rstep();
    step(1'b0, 8'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
         ($urandom_range(0, 3) != 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while ((cyc + 1 < m_back_ready) && n < 200) begin rstep(); n++; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1; cyc++;
    reset = 1'b0;
    m_front_ok = 1'b0; m_back_ok = 1'b0; last_pix = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ce", 32'(ram_ce), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix", 32'(pix), 0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] code;
    int n;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[11'h608] = 8'h0C; mem[11'h609] = 8'h1E; mem[11'h60A] = 8'h33; mem[11'h60B] = 8'h33;
    mem[11'h60C] = 8'h3F; mem[11'h60D] = 8'h33; mem[11'h60E] = 8'h33; mem[11'h60F] = 8'h00;

    @(posedge clk); #1; cyc++;
    do_reset();

    // 'A' plain, then inverted
    for (int pass = 0; pass < 2; pass++) begin
      mem[0] = (pass == 0) ? 8'h41 : 8'hC1;
      pat    = (pass == 0) ? 8'h0C : 8'hF3;
      step(1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
      idle(66);
      step(1'b1, 8'd1, 1'b0, 8'd0, 1'b0);
      for (int x = 0; x < 8; x++) begin
        step(1'b0, 8'd0, 1'b1, 8'(x), 1'b1);
        chk("glyph_A", 32'(pix), 32'(pat[x]));
      end
      wait_fetch();
    end

    // Last text line: full address sequence and busy length
    step(1'b1, 8'd223, 1'b0, 8'd0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      chk("y223_busy", 32'(busy), 1);
      chk("y223_ce_c", 32'(ram_ce), 1);
      chk("y223_char_addr", 32'(ram_addr), 32'h360 + 32'(c));
      step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
      code = mem[11'h360 + 11'(c)];
      chk("y223_busy", 32'(busy), 1);
      chk("y223_ce_g", 32'(ram_ce), 1);
      chk("y223_glyph_addr", 32'(ram_addr), (32'h400 + 32'(code[6:0]) * 8 + 7) % 2048);
      step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    end
    chk("y223_drain_busy", 32'(busy), 1);
    chk("y223_drain_ce", 32'(ram_ce), 0);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    chk("y223_busy_end", 32'(busy), 0);

    // Blank line: no RAM traffic, blank after swap
    step(1'b1, 8'd224, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("y224_ce", 32'(ram_ce), 0);
      chk("y224_busy", 32'(busy), 0);
      step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    end
    step(1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      chk("y224_blank", 32'(pix), 0);
    end
    wait_fetch();

    // Restart mid-fetch; the same cycle also requests a pixel from the pre-swap front
    step(1'b1, 8'd8, 1'b0, 8'd0, 1'b0);
    idle(19);
    step(1'b1, 8'd8, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    chk("restart_ce", 32'(ram_ce), 1);
    chk("restart_addr", 32'(ram_addr), 32'h020);
    n = 0;
    while (busy && n < 100) begin
      step(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      chk("restart_blank", 32'(pix), 0);
      n++;
    end
    chk("restart_busy_len", 32'(n), 65);

    // Reset mid-fetch
    step(1'b1, 8'd40, 1'b0, 8'd0, 1'b0);
    idle(10);
    do_reset();
    step(1'b1, 8'd16, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 70; i++) rstep();
    step(1'b1, 8'd17, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 70; i++) rstep();

    // Random lines, gaps (some too short), text rewrites and pixel traffic
    for (int it = 0; it < 40; it++) begin
      int gap;
      if ($urandom_range(0, 2) == 0) begin
        wait_fetch();
        for (int a = 0; a < 28 * 32; a++) mem[a] = 8'($urandom);
      end
      gap = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 64) : $urandom_range(66, 90);
      step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'b1);
      for (int i = 1; i < gap; i++) rstep();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/menu_text_reader.md
# menu_text_reader

Read-side engine for the 2 KB menu/OSD RAM. The CPU side writes text cells into the low area of the RAM. This block uses the other RAM port, once per scanline, to fetch the 32 character codes for that line and their glyph bytes from the font region at 0x400. It double-buffers the result and returns one overlay pixel per request from the video mixer.

## Interface
Parameters:
- FONT_BASE, 11'h400: byte address of glyph for code 0; glyph(c, r) = FONT_BASE + c*8 + r
- TEXT_BASE, 11'h000: byte address of text cell (row 0, col 0); cell = TEXT_BASE + row*32 + col
- TEXT_ROWS, 28: text rows; lines y ≥ TEXT_ROWS*8 are blank

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse; swap buffers and start fetch of line line_y
- line_y  in  8  scanline index to fetch (0..255)
- busy  out  1  fetch in progress
- ram_ce  out  1  RAM port read enable
- ram_addr  out  11  RAM port address
- ram_dout  in  8  RAM read data, valid exactly 1 cycle after ram_ce
- overlay_en  in  1  0 forces pix=0
- pix_req  in  1  pixel request
- pix_x  in  8  pixel column (0..255)
- pix_valid  out  1  pix is valid (pix_req delayed 1 cycle)
- pix  out  1  overlay pixel, 1 = lit

## Operation
- Cell code c: bits 6:0 give the glyph, and bit 7 inverts the glyph. Glyph byte bit 0 is the leftmost pixel.
- Line buffers: two banks (front/back). Each bank holds 32 glyph bytes, 32 invert bits and a blank flag.
- On line_start, front⇄back swap in the same edge. A fetch of line_y into the new back bank then starts.
- FSM states: IDLE, CHAR, GLYPH, DRAIN.
  - IDLE: on line_start with line_y < TEXT_ROWS*8, go to CHAR with col=0, row=line_y[7:3], r=line_y[2:0].
  - IDLE: on line_start with line_y ≥ TEXT_ROWS*8, set back.blank=1 and stay in IDLE.
  - CHAR: ram_ce=1, ram_addr=TEXT_BASE+row*32+col. If col>0, store ram_dout as the glyph byte of col-1. Go to GLYPH.
  - GLYPH: latch inv=ram_dout[7]. ram_ce=1, ram_addr=FONT_BASE+{ram_dout[6:0],r}. Go to CHAR with col+1, or to DRAIN if col=31.
  - DRAIN: store glyph of col 31, clear back.blank, go to IDLE.
- busy = (state ≠ IDLE). ram_ce=0 in IDLE and DRAIN.
- Address arithmetic is 11-bit and wraps modulo 2048.
- line_start while busy: swap anyway. The partially filled bank becomes front with blank=1. The fetch restarts at col 0 for the new line_y.
- Pixel path, registered:
  - pix_valid(t+1) = pix_req(t).
  - pix(t+1) = overlay_en & ~front.blank & (glyph[pix_x[7:3]][pix_x[2:0]] ^ inv[pix_x[7:3]]).
  - pix holds its value when pix_req=0.
- Reset values: state IDLE, busy 0, ram_ce 0, ram_addr 0, pix_valid 0, pix 0, both blank flags 1, front select 0.

## Timing
- line_start sampled at edge 0. CHAR for col c is in cycle 1+2c, GLYPH in cycle 2+2c. DRAIN is in cycle 65.
- busy is high for cycles 1..65 (65 cycles) and low from cycle 66.
- 64 RAM reads per line. The fetch fits in any hblank ≥ 66 clocks.
- Pixel latency is 1 cycle; one pixel per cycle is sustained. The pixel path is independent of the fetch FSM.
- line_start and pix_req in the same cycle: the pixel is read from the pre-swap front bank.

## Structure
- Package menu_pkg holds:
  - MENU_COLS=32, GLYPH_H=8
  - default FONT_BASE/TEXT_BASE
  - FSM state enum {IDLE, CHAR, GLYPH, DRAIN}
- Sub-module menu_line_buf: two banks of 32×(8-bit glyph + inv bit) plus blank flags and a front select. It has one write port (fetch side) and one combinational read port (pixel side).
- The top level contains the FSM, address generation and the pixel register.

## Test plan
Bench RAM model has 1-cycle latency and holds the 8×8 ASCII font at 0x400 ('A' = 0x41 at 0x608: 0C,1E,33,33,3F,33,33,00).
- Cell 0 = 0x41; line_start y=0; after busy falls, line_start y=1; then pix_x 0..7 → pix 0,0,1,1,0,0,0,0.
- Cell 0 = 0xC1, same sequence → pix 1,1,0,0,1,1,1,1.
- line_start y=223 → ram_addr sequence 0x360, 0x400+c*8+7, …; last char address 0x37F; busy high exactly 65 cycles.
- line_start y=224 → ram_ce stays 0, busy stays 0; after next swap every pix=0.
- line_start y=8 issued again at cycle 20 of a fetch → ram_addr returns to 0x020 on the next cycle; new front bank is blank (pix=0); busy falls 65 cycles later.
- reset asserted mid-fetch → next cycle busy=0, ram_ce=0, pix_valid=0; pixels are 0 until two clean fetch/swap cycles complete.
